fft_input_buffer: RTL and testbench

- Sits directly downstream of the receive symbol-output stage and upstream of the 64-point FFT.
- Collects indexed 64-sample complex symbols into a ping-pong buffer of 2 × 64 entries.
- Streams each completed symbol to the FFT over a valid/ready handshake, tagged with its symbol number.
- Decouples the continuous, non-stallable sample stream from the FFT's back-pressure.

---
 rtl/ofdm_rx_pkg.sv | 16 +
 rtl/fft_buf_bank_ram.sv | 24 ++
 rtl/fft_input_buffer.sv | 223 ++++++++++++++++++++++
 tb/tb_fft_input_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_pkg.sv
// Shared constants, writer state encoding and the bit-reversal helper for the
// OFDM receive path.
package ofdm_rx_pkg;
  localparam int N_FFT  = 64;
  localparam int N_LOG2 = 6;
  localparam int DATA_W = 8;
  localparam int SYM_W  = 8;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_e;

  function automatic logic [N_LOG2-1:0] bit_rev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_buf_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Both ping-pong banks share it; the bank select is the address MSB.
module fft_buf_bank_ram #(
  parameter int W  = 16,
  parameter int AW = 7
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong symbol buffer between the receive sample stream and the FFT.
// Define BIT_REVERSE_EN to stream each symbol in bit-reversed address order.
module fft_input_buffer #(
  parameter int DATA_W = ofdm_rx_pkg::DATA_W,
  parameter int N_LOG2 = ofdm_rx_pkg::N_LOG2,
  parameter int SYM_W  = ofdm_rx_pkg::SYM_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              DataInEnable,
  input  logic [DATA_W-1:0] DataInRe,
  input  logic [DATA_W-1:0] DataInIm,
  input  logic [N_LOG2-1:0] DataInIndex,
  input  logic [SYM_W-1:0]  SymbolIn,
  output logic              DataOutValid,
  input  logic              DataOutReady,
  output logic [DATA_W-1:0] DataOutRe,
  output logic [DATA_W-1:0] DataOutIm,
  output logic [N_LOG2-1:0] DataOutIndex,
  output logic              DataOutLast,
  output logic [SYM_W-1:0]  SymbolOut,
  output logic              Overflow,
  output logic              FrameErr
);
  import ofdm_rx_pkg::*;

  localparam logic [N_LOG2-1:0] LAST_IDX = '1;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic [N_LOG2-1:0] idx;
    logic              last;
    logic [SYM_W-1:0]  tag;
  } beat_t;

  // writer
  wr_state_e              st_q, st_d;
  logic                   wbank_q, wbank_d;
  logic [N_LOG2-1:0]      exp_q, exp_d;
  logic [1:0]             full_q, full_d;
  logic [1:0][SYM_W-1:0]  tag_q, tag_d;
  logic                   ovf_q, ovf_d, ferr_q, ferr_d;
  logic                   we, start, set_full, bank_free;

  // reader: issue pointer runs ahead of the free pointer so the next bank
  // can be fetched while the previous symbol's tail is still in the output
  logic                   iss_bank_q, iss_bank_d;
  logic [N_LOG2-1:0]      iss_cnt_q, iss_cnt_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [N_LOG2-1:0]      rd_addr;
  logic                   issue, pop, clr;
  logic [1:0]             occ;
  logic                   s1_vld_q, s1_vld_d;
  logic [N_LOG2-1:0]      s1_idx_q, s1_idx_d;
  logic                   s1_last_q, s1_last_d;
  logic [SYM_W-1:0]       s1_tag_q, s1_tag_d;
  logic [2*DATA_W-1:0]    ram_rdata;
  beat_t                  s1;
  beat_t                  out_q, out_d, skid_q, skid_d;
  logic                   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;

  assign bank_free = !full_q[wbank_q] || (clr && (rd_bank_q == wbank_q));

  always_comb begin
    st_d     = st_q;
    wbank_d  = wbank_q;
    exp_d    = exp_q;
    tag_d    = tag_q;
    ovf_d    = 1'b0;
    ferr_d   = 1'b0;
    we       = 1'b0;
    start    = 1'b0;
    set_full = 1'b0;
    if (DataInEnable) begin
      unique case (st_q)
        W_IDLE: start = (DataInIndex == '0);
        W_FILL: begin
          if (DataInIndex == exp_q) begin
            we    = 1'b1;
            exp_d = exp_q + 1'b1;
            if (DataInIndex == LAST_IDX) begin
              set_full = 1'b1;
              wbank_d  = ~wbank_q;
              st_d     = W_IDLE;
            end
          end else begin
            ferr_d = 1'b1;
            st_d   = W_IDLE;
            start  = (DataInIndex == '0);
          end
        end
        W_DROP: begin
          if (DataInIndex == '0)           start = 1'b1;
          else if (DataInIndex == LAST_IDX) st_d = W_IDLE;
        end
        default: st_d = W_IDLE;
      endcase
      if (start) begin
        if (bank_free) begin
          we             = 1'b1;
          tag_d[wbank_q] = SymbolIn;
          exp_d          = N_LOG2'(1);
          st_d           = W_FILL;
        end else begin
          ovf_d = 1'b1;
          st_d  = W_DROP;
        end
      end
    end
  end

`ifdef BIT_REVERSE_EN
  assign rd_addr = bit_rev(iss_cnt_q);
`else
  assign rd_addr = iss_cnt_q;
`endif

  assign pop   = out_vld_q && DataOutReady;
  assign clr   = pop && out_q.last;
  assign occ   = 2'(s1_vld_q) + 2'(out_vld_q) + 2'(skid_vld_q);
  // at most two beats in flight/buffered, so the skid slot never overflows
  assign issue = full_q[iss_bank_q] && ((occ - 2'(pop)) < 2'd2);
  assign s1    = '{re: ram_rdata[2*DATA_W-1:DATA_W], im: ram_rdata[DATA_W-1:0],
                   idx: s1_idx_q, last: s1_last_q, tag: s1_tag_q};

  always_comb begin
    full_d = full_q;
    if (clr)      full_d[rd_bank_q] = 1'b0;
    if (set_full) full_d[wbank_q]   = 1'b1;
    rd_bank_d  = clr ? ~rd_bank_q : rd_bank_q;
    iss_cnt_d  = issue ? iss_cnt_q + 1'b1 : iss_cnt_q;
    iss_bank_d = (issue && iss_cnt_q == LAST_IDX) ? ~iss_bank_q : iss_bank_q;
    s1_vld_d   = issue;
    s1_idx_d   = issue ? rd_addr : s1_idx_q;
    s1_last_d  = issue ? (iss_cnt_q == LAST_IDX) : s1_last_q;
    s1_tag_d   = issue ? tag_q[iss_bank_q] : s1_tag_q;

    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (pop) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = s1_vld_q;
        if (s1_vld_q) skid_d = s1;
      end else begin
        out_vld_d = s1_vld_q;
        if (s1_vld_q) out_d = s1;
      end
    end else if (s1_vld_q) begin
      if (!out_vld_q) begin
        out_vld_d = 1'b1;
        out_d     = s1;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = s1;
      end
    end
  end

  fft_buf_bank_ram #(.W(2*DATA_W), .AW(N_LOG2+1)) u_ram (
    .Clk   (Clk),
    .we    (we),
    .waddr ({wbank_q, DataInIndex}),
    .wdata ({DataInRe, DataInIm}),
    .re    (issue),
    .raddr ({iss_bank_q, rd_addr}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st_q       <= W_IDLE;
      wbank_q    <= 1'b0;
      exp_q      <= '0;
      full_q     <= '0;
      tag_q      <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
      iss_bank_q <= 1'b0;
      iss_cnt_q  <= '0;
      rd_bank_q  <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_tag_q   <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      wbank_q    <= wbank_d;
      exp_q      <= exp_d;
      full_q     <= full_d;
      tag_q      <= tag_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
      iss_bank_q <= iss_bank_d;
      iss_cnt_q  <= iss_cnt_d;
      rd_bank_q  <= rd_bank_d;
      s1_vld_q   <= s1_vld_d;
      s1_idx_q   <= s1_idx_d;
      s1_last_q  <= s1_last_d;
      s1_tag_q   <= s1_tag_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign DataOutValid = out_vld_q;
  assign DataOutRe    = out_q.re;
  assign DataOutIm    = out_q.im;
  assign DataOutIndex = out_q.idx;
  assign DataOutLast  = out_q.last;
  assign SymbolOut    = out_q.tag;
  assign Overflow     = ovf_q;
  assign FrameErr     = ferr_q;
endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench for fft_input_buffer; expectations follow BIT_REVERSE_EN.
module tb_fft_input_buffer;
  localparam int DW = 8, NL = 6, SW = 8;

  logic          Clk = 1'b0, Rst_n = 1'b0;
  logic          DataInEnable = 1'b0;
  logic [DW-1:0] DataInRe = '0, DataInIm = '0;
  logic [NL-1:0] DataInIndex = '0;
  logic [SW-1:0] SymbolIn = '0;
  logic          DataOutValid, DataOutReady, DataOutLast, Overflow, FrameErr;
  logic [DW-1:0] DataOutRe, DataOutIm;
  logic [NL-1:0] DataOutIndex;
  logic [SW-1:0] SymbolOut;

  fft_input_buffer #(.DATA_W(DW), .N_LOG2(NL), .SYM_W(SW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .DataInEnable(DataInEnable), .DataInRe(DataInRe),
    .DataInIm(DataInIm), .DataInIndex(DataInIndex), .SymbolIn(SymbolIn),
    .DataOutValid(DataOutValid), .DataOutReady(DataOutReady), .DataOutRe(DataOutRe),
    .DataOutIm(DataOutIm), .DataOutIndex(DataOutIndex), .DataOutLast(DataOutLast),
    .SymbolOut(SymbolOut), .Overflow(Overflow), .FrameErr(FrameErr));

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [NL-1:0] idx;
    logic          last;
    logic [SW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   ovf_cnt = 0, ferr_cnt = 0, rdy_mode = 0;
  int   sym_start = 0, last_end = 0, burst_len = -1, gap_seen = -1;
  bit   in_sym = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [NL-1:0] addr_of(input int k);
    logic [NL-1:0] n, r;
    n = NL'(k);
    for (int i = 0; i < NL; i++) r[i] = n[NL-1-i];
`ifdef BIT_REVERSE_EN
    return r;
`else
    return n;
`endif
  endfunction

  function automatic logic [DW-1:0] im_of(input logic [NL-1:0] a, input logic [SW-1:0] t);
    logic [DW-1:0] v;
    v = DW'(0) - DW'(a);
    return v ^ DW'(t);
  endfunction

  task automatic push_sym(input logic [SW-1:0] t);
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      e.idx  = addr_of(k);
      e.re   = DW'(e.idx);
      e.im   = im_of(e.idx, t);
      e.last = (k == 63);
      e.tag  = t;
      sb.push_back(e);
    end
  endtask

  task automatic send_range(input logic [SW-1:0] t, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge Clk); #1;
      DataInEnable = 1'b1;
      DataInIndex  = NL'(i);
      DataInRe     = DW'(i);
      DataInIm     = im_of(NL'(i), t);
      SymbolIn     = t;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; DataInEnable = 1'b0; end
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin @(negedge Clk); t++; end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d beats still pending, required 0", sb.size());
    end
  endtask

  // Ready driver
  initial begin
    DataOutReady = 1'b0;
    forever begin
      @(posedge Clk); #1;
      case (rdy_mode)
        0: DataOutReady = 1'b1;
        1: DataOutReady = 1'($urandom_range(0, 1));
        default: DataOutReady = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pop, stall-hold check, pulse and burst timing
  initial begin
    exp_t got, held, e;
    bit   held_v = 0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        held_v = 0;
        in_sym = 0;
      end else begin
        if (Overflow) ovf_cnt++;
        if (FrameErr) ferr_cnt++;
        got = '{re: DataOutRe, im: DataOutIm, idx: DataOutIndex, last: DataOutLast, tag: SymbolOut};
        if (held_v) begin
          n_cmp++;
          if (!DataOutValid || got !== held) begin
            n_err++;
            $display("FAIL stall_hold: got v=%b %h required v=1 %h", DataOutValid, got, held);
          end
        end
        held_v = DataOutValid && !DataOutReady;
        held   = got;
        if (DataOutValid && DataOutReady) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out: got %h required no output", got);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              n_err++;
              $display("FAIL beat: got %h required %h", got, e);
            end
          end
          if (!in_sym) begin
            in_sym    = 1;
            sym_start = cyc;
            gap_seen  = cyc - last_end;
          end
          if (DataOutLast) begin
            in_sym    = 0;
            last_end  = cyc;
            burst_len = cyc - sym_start;
          end
        end
      end
    end
  end

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    n_cmp++; if (DataOutValid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b required 0", DataOutValid); end
    n_cmp++; if (DataOutRe !== '0)     begin n_err++; $display("FAIL rst_re: got %h required 0", DataOutRe); end
    n_cmp++; if (DataOutIm !== '0)     begin n_err++; $display("FAIL rst_im: got %h required 0", DataOutIm); end
    n_cmp++; if (DataOutIndex !== '0)  begin n_err++; $display("FAIL rst_idx: got %h required 0", DataOutIndex); end
    n_cmp++; if (DataOutLast !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b required 0", DataOutLast); end
    n_cmp++; if (SymbolOut !== '0)     begin n_err++; $display("FAIL rst_sym: got %h required 0", SymbolOut); end
    n_cmp++; if ({Overflow, FrameErr} !== 2'b00) begin n_err++; $display("FAIL rst_pulses: got %b required 00", {Overflow, FrameErr}); end
    #2 Rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    int o0 = ovf_cnt, f0 = ferr_cnt;
    push_sym(8'd5);
    send_range(8'd5, 0, 63);
    idle(1);
    @(negedge Clk);
    n_cmp++; if (DataOutValid !== 1'b0) begin n_err++; $display("FAIL lat_edge1: got %b required 0", DataOutValid); end
    @(negedge Clk);
    n_cmp++; if (DataOutValid !== 1'b0) begin n_err++; $display("FAIL lat_edge2: got %b required 0", DataOutValid); end
    @(negedge Clk);
    n_cmp++; if (DataOutValid !== 1'b1) begin n_err++; $display("FAIL lat_first_valid: got %b required 1", DataOutValid); end
    wait_drain(200);
    n_cmp++; if (burst_len != 63) begin n_err++; $display("FAIL burst_len: got %0d required 63", burst_len); end
    n_cmp++; if (ovf_cnt != o0 || ferr_cnt != f0) begin n_err++; $display("FAIL single_pulses: got ovf+%0d ferr+%0d required 0 0", ovf_cnt - o0, ferr_cnt - f0); end
  endtask

  task automatic test_backpressure();
    rdy_mode = 1;
    push_sym(8'd7);
    send_range(8'd7, 0, 63);
    idle(16);
    push_sym(8'd8);
    send_range(8'd8, 0, 63);
    idle(1);
    wait_drain(800);
    rdy_mode = 0;
    idle(2);
  endtask

  task automatic test_overflow();
    int o0;
    rdy_mode = 2;
    idle(2);
    o0 = ovf_cnt;
    push_sym(8'd1);
    push_sym(8'd2);
    send_range(8'd1, 0, 63); idle(16);
    send_range(8'd2, 0, 63); idle(16);
    send_range(8'd3, 0, 63); idle(8);
    n_cmp++; if (ovf_cnt - o0 != 1) begin n_err++; $display("FAIL overflow_pulses: got %0d required 1", ovf_cnt - o0); end
    @(negedge Clk);
    n_cmp++; if (DataOutValid !== 1'b1 || SymbolOut !== 8'd1) begin n_err++; $display("FAIL stalled_head: got v=%b tag=%0d required v=1 tag=1", DataOutValid, SymbolOut); end
    rdy_mode = 0;
    wait_drain(400);
    n_cmp++; if (gap_seen < 1 || gap_seen > 2) begin n_err++; $display("FAIL sym_gap: got %0d cycles required 1..2", gap_seen); end
    idle(4);
  endtask

  task automatic test_frame_err();
    int f0 = ferr_cnt, o0 = ovf_cnt;
    send_range(8'd4, 0, 20);
    send_range(8'd4, 22, 63);
    idle(16);
    push_sym(8'd9);
    send_range(8'd9, 0, 63);
    idle(1);
    wait_drain(200);
    n_cmp++; if (ferr_cnt - f0 != 1) begin n_err++; $display("FAIL frame_err_pulses: got %0d required 1", ferr_cnt - f0); end
    n_cmp++; if (ovf_cnt != o0) begin n_err++; $display("FAIL frame_err_ovf: got %0d required 0", ovf_cnt - o0); end
  endtask

  task automatic test_reset_mid();
    push_sym(8'd11);
    send_range(8'd11, 0, 63);
    idle(30);
    #2 Rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({DataOutValid, DataOutRe, DataOutIm, DataOutIndex, DataOutLast, SymbolOut, Overflow, FrameErr} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got v=%b re=%h tag=%h required all 0", DataOutValid, DataOutRe, SymbolOut);
    end
    sb.delete();
    repeat (3) @(posedge Clk);
    #3 Rst_n = 1'b1;
    @(negedge Clk);
    n_cmp++; if (DataOutValid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b required 0", DataOutValid); end
    push_sym(8'd12);
    send_range(8'd12, 0, 63);
    idle(1);
    wait_drain(200);
    n_cmp++; if (burst_len != 63) begin n_err++; $display("FAIL post_reset_burst: got %0d required 63", burst_len); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_frame_err();
    test_reset_mid();
    idle(80);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
